multicycle_control_unit: RTL and testbench

- Main control unit for the team's 32-bit MIPS-subset multicycle datapath.
- Decodes the current instruction word and drives every datapath select and enable: PC write, memory address select, instruction latch, ALU operand selects, ALU operation, register-file write, and writeback select.
- Most instructions complete in one cycle; lw, sw and blt take two cycles ("rounds"), tracked by a two-state FSM.

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/alu_op_decoder.sv | 32 +++
 rtl/multicycle_control_unit.sv | 152 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, functs,
// ALU operation codes, datapath mux selects and the two-round FSM state.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_NORI  = 6'b001110;
    localparam logic [5:0] OP_BLT   = 6'b000111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] SRCB_RD2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic {FIRST, SECOND} state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// ALU operation decode from opcode and funct.
// Latency: combinational. Backpressure: none.
// Unknown encodings fall back to add so the ALU output is always defined.
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [4:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_NOR:  alu_control = ALU_NOR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            OP_NORI: alu_control = ALU_NOR;
            OP_BLT:  alu_control = ALU_SUB;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control for the multicycle MIPS-subset datapath; lw/sw/blt use two rounds.
// Latency: outputs combinational from state and instr; state advances per clock.
// Backpressure: none; reset gates all write enables and aborts an in-flight second round.
module multicycle_control_unit
    import ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        PCWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        secondRound,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        ALUSrc,
    output logic [4:0]  ALUControl,
    output logic        alu4,
    output logic        alu3,
    output logic        alu2,
    output logic        alu1,
    output logic        alu0,
    output logic        regDst,
    output logic        regWriteEnable,
    output logic        memToReg,
    output logic        memWrite,
    output logic        branchEnable,
    output logic        jump,
    output logic        jumpReg,
    output logic [1:0]  PCSrc
);

    state_t     state;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] dec_alu;
    logic       two_round;
    logic       pc_we, ir_we, rf_we, mem_we, br_en;
    logic       unused_instr;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign two_round    = (op == OP_LW) || (op == OP_SW) || (op == OP_BLT);
    assign unused_instr = ^instr[25:6];

    alu_op_decoder u_alu_dec (
        .op          (op),
        .funct       (funct),
        .alu_control (dec_alu)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= FIRST;
        else if (state == FIRST && two_round)
            state <= SECOND;
        else
            state <= FIRST;
    end

    always_comb begin
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        mem_we      = 1'b0;
        br_en       = 1'b0;
        IorD        = 1'b0;
        secondRound = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RD2;
        ALUControl  = dec_alu;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        jump        = 1'b0;
        jumpReg     = 1'b0;
        PCSrc       = PCSRC_PC4;
        if (state == FIRST) begin
            case (op)
                OP_RTYPE: begin
                    pc_we = 1'b1;
                    case (funct)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: begin
                            regDst = 1'b1;
                            rf_we  = 1'b1;
                        end
                        FN_JR: begin
                            PCSrc   = PCSRC_JUMP;
                            jumpReg = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_ADDI, OP_NORI: begin
                    pc_we   = 1'b1;
                    rf_we   = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                OP_J: begin
                    pc_we = 1'b1;
                    PCSrc = PCSRC_JUMP;
                end
                OP_JAL: begin
                    pc_we = 1'b1;
                    PCSrc = PCSRC_JUMP;
                    jump  = 1'b1;
                    rf_we = 1'b1;
                end
                OP_LW, OP_SW: ir_we = 1'b1;
                OP_BLT: begin
                    // Round 1 computes PC+4 + (imm<<2) and parks it in the branch latch.
                    ir_we      = 1'b1;
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM_SH2;
                    ALUControl = ALU_ADD;
                    br_en      = 1'b1;
                end
                default: pc_we = 1'b1;
            endcase
        end else begin
            secondRound = 1'b1;
            pc_we       = 1'b1;
            case (op)
                OP_LW: begin
                    IorD     = 1'b1;
                    ALUSrcB  = SRCB_IMM;
                    memToReg = 1'b1;
                    rf_we    = 1'b1;
                end
                OP_SW: begin
                    IorD    = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    mem_we  = 1'b1;
                end
                OP_BLT: PCSrc = PCSRC_BRANCH;
                default: ;
            endcase
        end
        PCWrite        = pc_we  && !reset;
        IRWrite        = ir_we  && !reset;
        regWriteEnable = rf_we  && !reset;
        memWrite       = mem_we && !reset;
        branchEnable   = br_en  && !reset;
    end

    assign ALUSrc = (ALUSrcB == SRCB_IMM);
    assign alu4   = ALUControl[4];
    assign alu3   = ALUControl[3];
    assign alu2   = ALUControl[2];
    assign alu1   = ALUControl[1];
    assign alu0   = ALUControl[0];

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus queues hand-computed
// control vectors, a negedge monitor pops and compares against the DUT.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       PCWrite;
        logic       IorD;
        logic       IRWrite;
        logic       secondRound;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       ALUSrc;
        logic [4:0] ALUControl;
        logic [4:0] aluBits;
        logic       regDst;
        logic       regWriteEnable;
        logic       memToReg;
        logic       memWrite;
        logic       branchEnable;
        logic       jump;
        logic       jumpReg;
        logic [1:0] PCSrc;
    } ctl_t;

    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BLT  = 32'h1C220003;
    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_AND  = 32'h00221824;
    localparam logic [31:0] I_OR   = 32'h00221825;
    localparam logic [31:0] I_NOR  = 32'h00221827;
    localparam logic [31:0] I_SLT  = 32'h0022182A;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_JR   = 32'h03E00008;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_ADDI = 32'h20220005;
    localparam logic [31:0] I_NORI = 32'h38220005;
    localparam logic [31:0] I_BADO = 32'hFC000000;
    localparam logic [31:0] I_BADF = 32'h0000003F;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        PCWrite, IorD, IRWrite, secondRound, ALUSrcA, ALUSrc;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [4:0]  ALUControl;
    logic        alu4, alu3, alu2, alu1, alu0;
    logic        regDst, regWriteEnable, memToReg, memWrite, branchEnable, jump, jumpReg;

    multicycle_control_unit dut (
        .clock          (clock),
        .reset          (reset),
        .instr          (instr),
        .PCWrite        (PCWrite),
        .IorD           (IorD),
        .IRWrite        (IRWrite),
        .secondRound    (secondRound),
        .ALUSrcA        (ALUSrcA),
        .ALUSrcB        (ALUSrcB),
        .ALUSrc         (ALUSrc),
        .ALUControl     (ALUControl),
        .alu4           (alu4),
        .alu3           (alu3),
        .alu2           (alu2),
        .alu1           (alu1),
        .alu0           (alu0),
        .regDst         (regDst),
        .regWriteEnable (regWriteEnable),
        .memToReg       (memToReg),
        .memWrite       (memWrite),
        .branchEnable   (branchEnable),
        .jump           (jump),
        .jumpReg        (jumpReg),
        .PCSrc          (PCSrc)
    );

    ctl_t  act;
    ctl_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    assign act = {PCWrite, IorD, IRWrite, secondRound, ALUSrcA, ALUSrcB, ALUSrc,
                  ALUControl, {alu4, alu3, alu2, alu1, alu0}, regDst, regWriteEnable,
                  memToReg, memWrite, branchEnable, jump, jumpReg, PCSrc};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            ctl_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    end

    function automatic ctl_t dflt();
        ctl_t e;
        e = '0;
        e.ALUControl = 5'b00010;
        return e;
    endfunction

    task automatic step(input logic rst, input logic [31:0] ins, input ctl_t e, input string nm);
        @(posedge clock);
        #1;
        reset = rst;
        instr = ins;
        e.aluBits = e.ALUControl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    function automatic ctl_t single_r(input logic [4:0] alu);
        ctl_t e;
        e = dflt();
        e.PCWrite = 1'b1;
        e.regDst = 1'b1;
        e.regWriteEnable = 1'b1;
        e.ALUControl = alu;
        return e;
    endfunction

    initial begin
        ctl_t e;
        int   budget;
        reset = 1'b1;
        instr = I_LW;

        step(1'b1, I_LW, dflt(), "reset_c1");
        step(1'b1, I_LW, dflt(), "reset_c2");

        step(1'b0, I_ADD, single_r(5'b00010), "add");

        e = dflt(); e.IRWrite = 1'b1;
        step(1'b0, I_LW, e, "lw_r1");
        e = dflt(); e.secondRound = 1'b1; e.IorD = 1'b1; e.ALUSrcB = 2'b10; e.ALUSrc = 1'b1;
        e.memToReg = 1'b1; e.regWriteEnable = 1'b1; e.PCWrite = 1'b1;
        step(1'b0, I_LW, e, "lw_r2");
        step(1'b0, I_ADD, single_r(5'b00010), "after_lw_first");

        e = dflt(); e.IRWrite = 1'b1;
        step(1'b0, I_SW, e, "sw_r1");
        e = dflt(); e.secondRound = 1'b1; e.IorD = 1'b1; e.ALUSrcB = 2'b10; e.ALUSrc = 1'b1;
        e.memWrite = 1'b1; e.PCWrite = 1'b1;
        step(1'b0, I_SW, e, "sw_r2");

        e = dflt(); e.IRWrite = 1'b1; e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b11; e.branchEnable = 1'b1;
        step(1'b0, I_BLT, e, "blt_r1");
        e = dflt(); e.secondRound = 1'b1; e.ALUControl = 5'b00110; e.PCSrc = 2'b10; e.PCWrite = 1'b1;
        step(1'b0, I_BLT, e, "blt_r2");

        e = dflt(); e.PCWrite = 1'b1; e.PCSrc = 2'b01; e.jump = 1'b1; e.regWriteEnable = 1'b1;
        step(1'b0, I_JAL, e, "jal");
        e = dflt(); e.PCWrite = 1'b1; e.PCSrc = 2'b01; e.jumpReg = 1'b1;
        step(1'b0, I_JR, e, "jr");
        e = dflt(); e.PCWrite = 1'b1; e.PCSrc = 2'b01;
        step(1'b0, I_J, e, "j");

        e = dflt(); e.PCWrite = 1'b1; e.regWriteEnable = 1'b1; e.ALUSrcB = 2'b10; e.ALUSrc = 1'b1;
        step(1'b0, I_ADDI, e, "addi");
        e.ALUControl = 5'b01100;
        step(1'b0, I_NORI, e, "nori");

        step(1'b0, I_SUB, single_r(5'b00110), "sub");
        step(1'b0, I_AND, single_r(5'b00000), "and");
        step(1'b0, I_OR,  single_r(5'b00001), "or");
        step(1'b0, I_NOR, single_r(5'b01100), "nor");
        step(1'b0, I_SLT, single_r(5'b00111), "slt");

        e = dflt(); e.PCWrite = 1'b1;
        step(1'b0, I_BADO, e, "unknown_op");
        step(1'b0, I_BADF, e, "unknown_funct");

        // Reset during the second round of lw: write enables drop, next cycle is FIRST.
        e = dflt(); e.IRWrite = 1'b1;
        step(1'b0, I_LW, e, "abort_lw_r1");
        e = dflt(); e.secondRound = 1'b1; e.IorD = 1'b1; e.ALUSrcB = 2'b10; e.ALUSrc = 1'b1;
        e.memToReg = 1'b1;
        step(1'b1, I_LW, e, "abort_lw_r2_reset");
        step(1'b0, I_ADD, single_r(5'b00010), "after_abort");

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clock);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
